// File: rtl/fsk_demodulator.sv
// 8-FSK demodulator: hunts for the sync marker (sine=0x0FFFF, cos=0 held
// SYNC_MIN samples), aligns on the first non-marker sample, then times
// back-to-back SYMBOL_LEN-sample windows. In each window it counts forward
// I/Q quadrant steps and maps that count to a 3-bit tone index.
//
// Ports:
//   clk         system clock
//   reset       asynchronous active-low reset
//   in_valid    sine_in/cos_in carry a new sample this cycle
//   sine_in     signed in-phase sample
//   cos_in      signed quadrature sample
//   data_out    recovered symbol, held until the next strobe
//   data_valid  one-cycle strobe, data_out/tone_err valid
//   tone_err    window step count below BIN_WIDTH/2 (no tone detected)
//   sync_locked high while symbol windows are being timed
module fsk_demodulator #(
  parameter int unsigned SAMPLE_W   = 18,
  parameter int unsigned SYMBOL_LEN = 1000,
  parameter int unsigned BIN_WIDTH  = 40,
  parameter int unsigned SYNC_MIN   = 8,
  parameter int unsigned COUNT_W    = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] sine_in,
  input  logic [SAMPLE_W-1:0] cos_in,
  output logic [2:0]          data_out,
  output logic                data_valid,
  output logic                tone_err,
  output logic                sync_locked
);

  localparam int unsigned RUN_W = $clog2(SYNC_MIN + 1);
  localparam logic [SAMPLE_W-1:0] MARKER_SIN = SAMPLE_W'(18'h0FFFF);
  localparam logic [RUN_W-1:0]    RUN_MAX    = RUN_W'(SYNC_MIN);
  localparam logic [COUNT_W-1:0]  SAMP_LAST  = COUNT_W'(SYMBOL_LEN - 1);
  localparam logic [COUNT_W-1:0]  HALF_BIN   = COUNT_W'(BIN_WIDTH / 2);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ALIGN  = 2'd1,
    SYMBOL = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [RUN_W-1:0]     run_cnt_q, run_cnt_d;
  logic [1:0]           q_prev_q, q_prev_d;
  logic [COUNT_W-1:0]   samp_cnt_q, samp_cnt_d;
  logic [COUNT_W-1:0]   step_cnt_q, step_cnt_d;
  logic                 dec_pend_q, dec_pend_d;
  logic [COUNT_W-1:0]   dec_cnt_q, dec_cnt_d;
  logic [2:0]           data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 tone_err_q, tone_err_d;
  logic                 sync_locked_q, sync_locked_d;

  logic                 marker_c;
  logic [1:0]           q_new_c;
  logic                 fwd_step_c;
  logic [COUNT_W-1:0]   step_next_c;
  logic [2:0]           tone_idx_c;

  // Marker detect and quadrant of the incoming sample
  always_comb begin
    marker_c = (sine_in == MARKER_SIN) && (cos_in == '0);
    unique case ({sine_in[SAMPLE_W-1], cos_in[SAMPLE_W-1]})
      2'b00:   q_new_c = 2'd0;
      2'b01:   q_new_c = 2'd1;
      2'b11:   q_new_c = 2'd2;
      default: q_new_c = 2'd3;
    endcase
    fwd_step_c  = (q_new_c == 2'(q_prev_q + 2'd1));
    step_next_c = (fwd_step_c && (step_cnt_q != '1)) ? step_cnt_q + COUNT_W'(1) : step_cnt_q;
  end

  // Tone index: highest k whose threshold k*BIN_WIDTH + BIN_WIDTH/2 is reached
  always_comb begin
    tone_idx_c = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (dec_cnt_q >= COUNT_W'(k * BIN_WIDTH + BIN_WIDTH / 2)) begin
        tone_idx_c = 3'(k);
      end
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d       = state_q;
    run_cnt_d     = run_cnt_q;
    q_prev_d      = q_prev_q;
    samp_cnt_d    = samp_cnt_q;
    step_cnt_d    = step_cnt_q;
    dec_pend_d    = 1'b0;
    dec_cnt_d     = dec_cnt_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    tone_err_d    = tone_err_q;
    sync_locked_d = sync_locked_q;

    // Decision stage: runs the cycle after window completion regardless of in_valid
    if (dec_pend_q) begin
      data_valid_d = 1'b1;
      tone_err_d   = (dec_cnt_q < HALF_BIN);
      data_out_d   = (dec_cnt_q < HALF_BIN) ? 3'd0 : tone_idx_c;
    end

    if (in_valid) begin
      if (marker_c) begin
        run_cnt_d = (run_cnt_q == RUN_MAX) ? run_cnt_q : run_cnt_q + RUN_W'(1);
      end else begin
        run_cnt_d = '0;
      end
      q_prev_d = q_new_c;

      unique case (state_q)
        HUNT: begin
          if (run_cnt_d == RUN_MAX) state_d = ALIGN;
        end
        ALIGN: begin
          // First non-marker sample only seeds q_prev; it is sample 1 of the window
          if (!marker_c) begin
            samp_cnt_d    = COUNT_W'(1);
            step_cnt_d    = '0;
            sync_locked_d = 1'b1;
            state_d       = SYMBOL;
          end
        end
        SYMBOL: begin
          if (run_cnt_d == RUN_MAX) begin
            // Re-sync wins over a window completing on the same sample
            state_d       = ALIGN;
            sync_locked_d = 1'b0;
            samp_cnt_d    = '0;
            step_cnt_d    = '0;
          end else if (samp_cnt_q == SAMP_LAST) begin
            dec_pend_d = 1'b1;
            dec_cnt_d  = step_next_c;
            samp_cnt_d = '0;
            step_cnt_d = '0;
          end else begin
            samp_cnt_d = samp_cnt_q + COUNT_W'(1);
            step_cnt_d = step_next_c;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= HUNT;
      run_cnt_q     <= '0;
      q_prev_q      <= '0;
      samp_cnt_q    <= '0;
      step_cnt_q    <= '0;
      dec_pend_q    <= 1'b0;
      dec_cnt_q     <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      tone_err_q    <= 1'b0;
      sync_locked_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      run_cnt_q     <= run_cnt_d;
      q_prev_q      <= q_prev_d;
      samp_cnt_q    <= samp_cnt_d;
      step_cnt_q    <= step_cnt_d;
      dec_pend_q    <= dec_pend_d;
      dec_cnt_q     <= dec_cnt_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      tone_err_q    <= tone_err_d;
      sync_locked_q <= sync_locked_d;
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign tone_err    = tone_err_q;
  assign sync_locked = sync_locked_q;

endmodule

// File: tb/tb_fsk_demodulator.sv
// Directed bench for fsk_demodulator: square-wave I/Q tones from a 16-bit
// phase accumulator, expected symbols queued when a window is driven and
// compared when data_valid strobes.
module tb_fsk_demodulator;

  localparam logic [17:0] AMP_P  = 18'd40000;
  localparam logic [17:0] AMP_N  = 18'h363C0;   // -40000
  localparam logic [17:0] MK_SIN = 18'h0FFFF;

  typedef struct {
    logic [2:0]  data;
    logic        err;
    int unsigned cyc;   // 0: strobe cycle not checked
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [17:0] sine_in;
  logic [17:0] cos_in;
  logic [2:0]  data_out;
  logic        data_valid;
  logic        tone_err;
  logic        sync_locked;

  exp_t        exp_q[$];
  int          vectors;
  int          miscompares;
  int unsigned cyc;
  int unsigned base;
  logic [15:0] phase;

  always #5 clk = ~clk;

  fsk_demodulator dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .sine_in    (sine_in),
    .cos_in     (cos_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .tone_err   (tone_err),
    .sync_locked(sync_locked)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock; sample DUT 1 time unit after the edge and score any strobe
  task automatic step(input logic v, input logic [17:0] s, input logic [17:0] c);
    exp_t e;
    in_valid = v;
    sine_in  = s;
    cos_in   = c;
    @(posedge clk);
    cyc++;
    #1;
    if (data_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 32'(data_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("data_out", 32'(data_out), 32'(e.data));
        check("tone_err", 32'(tone_err), 32'(e.err));
        if (e.cyc != 0) check("strobe_cycle", cyc, e.cyc);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 18'd0, 18'd0);
  endtask

  task automatic marker(input int n);
    for (int i = 0; i < n; i++) step(1'b1, MK_SIN, 18'd0);
  endtask

  // n valid tone samples; with gap=1 each is followed by an invalid marker-valued cycle
  task automatic tone(input logic [15:0] inc, input int n, input logic gap);
    logic [17:0] s;
    logic [17:0] c;
    for (int i = 0; i < n; i++) begin
      s = phase[15] ? AMP_N : AMP_P;
      c = (phase[15] ^ phase[14]) ? AMP_N : AMP_P;
      step(1'b1, s, c);
      phase = phase + inc;
      if (gap) step(1'b0, MK_SIN, 18'd0);
    end
  endtask

  task automatic push(input logic [2:0] d, input logic err, input int unsigned cy);
    exp_t e;
    e.data = d;
    e.err  = err;
    e.cyc  = cy;
    exp_q.push_back(e);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    phase       = 16'd0;
    reset       = 1'b0;
    in_valid    = 1'b0;
    sine_in     = '0;
    cos_in      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_tone_err", 32'(tone_err), 32'd0);
    check("rst_sync_locked", 32'(sync_locked), 32'd0);
    reset = 1'b1;

    // Sync on 11 markers, then symbols 3,0,7,4,1 back-to-back, strobes 1000 clks apart
    marker(11);
    check("t1_unlocked_in_marker", 32'(sync_locked), 32'd0);
    base = cyc + 1;
    push(3'd3, 1'b0, base + 1000);
    push(3'd0, 1'b0, base + 2000);
    push(3'd7, 1'b0, base + 3000);
    push(3'd4, 1'b0, base + 4000);
    push(3'd1, 1'b0, base + 5000);
    tone(16'd2621, 1, 1'b0);
    check("t1_locked_first_sample", 32'(sync_locked), 32'd1);
    tone(16'd2621, 999, 1'b0);
    tone(16'd655, 1000, 1'b0);
    tone(16'd5243, 1000, 1'b0);
    tone(16'd3277, 1000, 1'b0);
    tone(16'd1311, 1000, 1'b0);
    idle(2);
    check("t2_all_strobes_seen", exp_q.size(), 32'd0);

    // Short marker run: must stay in HUNT
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    marker(5);
    tone(16'd1966, 1000, 1'b0);
    idle(2);
    check("t3_not_locked", 32'(sync_locked), 32'd0);

    // in_valid toggling during a k=5 symbol
    marker(11);
    push(3'd5, 1'b0, 0);
    tone(16'd3932, 1000, 1'b1);
    idle(2);
    check("t4_strobe_seen", exp_q.size(), 32'd0);

    // Marker re-inserted at sample 600: window aborted, realign, decode k=6
    tone(16'd1966, 599, 1'b0);
    marker(10);
    check("t5_lock_dropped", 32'(sync_locked), 32'd0);
    push(3'd6, 1'b0, 0);
    tone(16'd4588, 1, 1'b0);
    check("t5_relocked", 32'(sync_locked), 32'd1);
    tone(16'd4588, 999, 1'b0);
    idle(2);
    check("t5_strobe_seen", exp_q.size(), 32'd0);

    // Constant input: no tone; then async reset mid-window
    push(3'd0, 1'b1, 0);
    repeat (1000) step(1'b1, 18'd100, 18'd100);
    idle(2);
    check("t6_strobe_seen", exp_q.size(), 32'd0);
    check("t6_tone_err_held", 32'(tone_err), 32'd1);
    check("t6_data_out_held", 32'(data_out), 32'd0);
    repeat (300) step(1'b1, 18'd100, 18'd100);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_data_out", 32'(data_out), 32'd0);
    check("t6_rst_data_valid", 32'(data_valid), 32'd0);
    check("t6_rst_tone_err", 32'(tone_err), 32'd0);
    check("t6_rst_sync_locked", 32'(sync_locked), 32'd0);
    idle(2);
    reset = 1'b1;
    tone(16'd3932, 1000, 1'b0);
    idle(2);
    check("t6_hunt_after_reset", 32'(sync_locked), 32'd0);
    check("t6_no_pending", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
